// File: rtl/fetch_pkg.sv
// Shared defaults and the decoded-entry type for the instruction fetch slice.
package fetch_pkg;

    localparam int unsigned         DEF_XLEN       = 32;
    localparam int unsigned         DEF_DEPTH      = 4;
    localparam int unsigned         DEF_PC_STEP    = 4;
    localparam logic [DEF_XLEN-1:0] DEF_RESET_ADDR = 32'h0000_0000;

    typedef struct packed {
        logic [DEF_XLEN-1:0] pc;
        logic [DEF_XLEN-1:0] inst;
    } inst_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous flush; head is read straight from storage.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_flush,
    input  logic                    i_push,
    input  logic [WIDTH-1:0]        i_data,
    input  logic                    i_pop,
    output logic [WIDTH-1:0]        o_data,
    output logic                    o_empty,
    output logic [$clog2(DEPTH):0]  o_count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign o_empty = (count == '0);
    assign o_count = count;
    assign o_data  = mem[rd_ptr];

    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign do_pop  = i_pop && !o_empty;
    assign do_push = i_push && (!full || do_pop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push && !i_flush) mem[wr_ptr] <= i_data;
    end

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Decoupled instruction prefetcher: credit-limited imem requests, PC tagging of
// in-order responses, and a flushable instruction queue feeding decode.
module fetch_prefetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned      XLEN       = DEF_XLEN,
    parameter logic [XLEN-1:0]  RESET_ADDR = XLEN'(DEF_RESET_ADDR),
    parameter int unsigned      DEPTH      = DEF_DEPTH,
    parameter int unsigned      PC_STEP    = DEF_PC_STEP
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_pc,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_gnt,
    input  logic            i_imem_rvalid,
    input  logic [XLEN-1:0] i_imem_rdata,
    output logic            o_inst_valid,
    output logic [XLEN-1:0] o_inst,
    output logic [XLEN-1:0] o_inst_pc,
    input  logic            i_inst_ready
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } entry_t;

    logic [XLEN-1:0] fetch_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   occupancy;
    logic [CW-1:0]   tag_count;
    logic [CW:0]     credit_sum;
    logic [XLEN-1:0] tag_pc;
    logic            tag_empty;
    logic            q_empty;
    entry_t          push_entry;
    entry_t          head_entry;
    logic            grant;
    logic            rsp_ok;
    logic            rsp_keep;
    logic            rsp_drop;
    logic            pop;

    assign credit_sum   = {1'b0, occupancy} + {1'b0, outstanding};
    assign o_imem_req   = i_rst_n && !i_redirect && (credit_sum < (CW+1)'(DEPTH));
    assign o_imem_addr  = fetch_pc;
    assign grant        = o_imem_req && i_imem_gnt;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp_ok       = i_imem_rvalid && (outstanding != '0);
    assign rsp_drop     = rsp_ok && (drop_cnt != '0);
    assign rsp_keep     = rsp_ok && (drop_cnt == '0);

    assign o_inst_valid = !q_empty && !i_redirect;
    assign pop          = o_inst_valid && i_inst_ready;
    assign o_inst       = q_empty ? '0 : head_entry.inst;
    assign o_inst_pc    = q_empty ? '0 : head_entry.pc;

    assign push_entry.pc   = tag_pc;
    assign push_entry.inst = i_imem_rdata;

    sync_fifo #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_flush (i_redirect),
        .i_push  (grant),
        .i_data  (fetch_pc),
        .i_pop   (rsp_keep),
        .o_data  (tag_pc),
        .o_empty (tag_empty),
        .o_count (tag_count)
    );

    sync_fifo #(
        .WIDTH (2*XLEN),
        .DEPTH (DEPTH)
    ) u_inst_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_flush (i_redirect),
        .i_push  (rsp_keep),
        .i_data  (push_entry),
        .i_pop   (pop),
        .o_data  (head_entry),
        .o_empty (q_empty),
        .o_count (occupancy)
    );

    // On redirect every request still in flight, minus the one answering now, becomes stale.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fetch_pc    <= RESET_ADDR;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else if (i_redirect) begin
            fetch_pc    <= i_redirect_pc;
            outstanding <= outstanding - CW'(rsp_ok);
            drop_cnt    <= outstanding - CW'(rsp_ok);
        end else begin
            if (grant) fetch_pc <= fetch_pc + XLEN'(PC_STEP);
            outstanding <= outstanding + CW'(grant) - CW'(rsp_ok);
            if (rsp_drop) drop_cnt <= drop_cnt - CW'(1);
        end
    end

    property p_no_orphan_rsp;
        @(posedge i_clk) disable iff (!i_rst_n) i_imem_rvalid |-> (outstanding != '0);
    endproperty
    a_no_orphan_rsp: assert property (p_no_orphan_rsp);

    property p_tag_tracks_live;
        @(posedge i_clk) disable iff (!i_rst_n) (tag_count == outstanding - drop_cnt) && (tag_empty == (tag_count == '0));
    endproperty
    a_tag_tracks_live: assert property (p_tag_tracks_live);

endmodule
